// File: rtl/button_cmd_pkg.sv
// Shared types and helpers for the button command scheduler.
//   cmd_op_t      : command code sent to the LED counter datapath
//   sched_state_t : scheduler FSM states
//   max3()        : elaboration-time helper for sizing the shared timer
//   prio_sel()    : fixed-priority button select (INC > DEC > SHL > CLR)
package button_cmd_pkg;

    typedef enum logic [1:0] {
        OP_INC = 2'd0,
        OP_DEC = 2'd1,
        OP_SHL = 2'd2,
        OP_CLR = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        ISSUE    = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Lowest set bit wins; an all-zero vector maps to CLR but is never used
    // because the caller only selects when some button is active.
    function automatic cmd_op_t prio_sel(input logic [3:0] btn);
        cmd_op_t op;
        if (btn[0]) begin
            op = OP_INC;
        end else if (btn[1]) begin
            op = OP_DEC;
        end else if (btn[2]) begin
            op = OP_SHL;
        end else begin
            op = OP_CLR;
        end
        return op;
    endfunction

endpackage

// File: rtl/button_cmd_sched.sv
// Button command scheduler: debounces four synchronized button levels,
// arbitrates between them, auto-repeats INC/DEC/SHL while held and hands
// each command to the counter over a valid/ready handshake.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   btn_in_i     : synchronized button levels [0]=INC [1]=DEC [2]=SHL [3]=CLR
//   cmd_ready_i  : counter accepts the pending command this cycle
//   cmd_valid_o  : command pending
//   cmd_op_o     : command code, stable while cmd_valid_o is high
//   busy_o       : scheduler is serving a press (not idle)
//   repeating_o  : at least one auto-repeat has issued for the current press
module button_cmd_sched
    import button_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_in_i,
    input  logic       cmd_ready_i,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_op_o,
    output logic       busy_o,
    output logic       repeating_o
);

    localparam int TMAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int TW   = $clog2(TMAX + 1);

    // Terminal counts are compared against the value before increment, so a
    // phase lasting N cycles ends when the timer reads N-1.
    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
    localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
    localparam logic [TW-1:0] T_SAT     = {TW{1'b1}};

    sched_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    cmd_op_t       sel_q, sel_d;
    logic          first_q, first_d;
    logic          rep_q, rep_d;
    logic          cmd_valid_q;
    cmd_op_t       cmd_op_q;
    logic          busy_q;

    logic [1:0]    sel_idx_s;
    logic          btn_sel_s;
    logic [TW-1:0] timer_inc_s;
    logic [TW-1:0] thr_last_s;

    assign sel_idx_s   = sel_q;
    assign btn_sel_s   = btn_in_i[sel_idx_s];
    // Timer saturates instead of wrapping (matters for a long-held CLR).
    assign timer_inc_s = (timer_q == T_SAT) ? timer_q : (timer_q + TW'(1));
    assign thr_last_s  = first_q ? DLY_LAST : RATE_LAST;

    // Next-state logic: press/release debounce, handshake and repeat timing.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        first_d = first_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (btn_in_i != 4'b0000) begin
                    sel_d   = prio_sel(btn_in_i);
                    timer_d = T_ZERO;
                    state_d = DEBOUNCE;
                end else begin
                    state_d = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!btn_sel_s) begin
                    state_d = IDLE;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ISSUE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ISSUE: begin
                // Timer frozen here: a stalled counter delays repeats.
                if (cmd_ready_i) begin
                    timer_d = T_ZERO;
                    state_d = HELD;
                end else begin
                    state_d = ISSUE;
                end
            end
            HELD: begin
                if (!btn_sel_s) begin
                    timer_d = T_ZERO;
                    state_d = RELEASE;
                end else if ((sel_q != OP_CLR) && (timer_q == thr_last_s)) begin
                    first_d = 1'b0;
                    rep_d   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            RELEASE: begin
                if (btn_sel_s) begin
                    timer_d = T_ZERO;
                end else if (timer_q == DEB_LAST) begin
                    first_d = 1'b1;
                    rep_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timer and registered outputs (outputs follow the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= T_ZERO;
            sel_q       <= OP_INC;
            first_q     <= 1'b1;
            rep_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_INC;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sel_q       <= sel_d;
            first_q     <= first_d;
            rep_q       <= rep_d;
            cmd_valid_q <= (state_d == ISSUE);
            if (state_d == ISSUE) begin
                cmd_op_q <= sel_d;
            end else begin
                cmd_op_q <= cmd_op_q;
            end
            busy_q      <= (state_d != IDLE);
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_op_o    = cmd_op_q;
    assign busy_o      = busy_q;
    assign repeating_o = rep_q;

endmodule

// File: tb/tb_button_cmd_sched.sv
// Self-checking bench for button_cmd_sched with short timing parameters.
// A timeline model (waits on clock edges, counts held/released cycles)
// predicts the outputs; a compare process checks them every cycle, and
// directed scenarios pin event timing with hand-computed literals.
module tb_button_cmd_sched;
    import button_cmd_pkg::*;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       ready = 1'b1;
    logic       valid;
    logic [1:0] op;
    logic       busy;
    logic       rep;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit model_on = 1'b0;

    logic       exp_valid = 1'b0;
    logic [1:0] exp_op    = 2'd0;
    logic       exp_busy  = 1'b0;
    logic       exp_rep   = 1'b0;

    int   press_cyc = 0;
    int   rel_cyc   = 0;
    int   rises[$];
    int   rise_ops[$];
    int   rise_rep[$];
    int   busy_fall  = -1;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;

    button_cmd_sched #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in_i   (btn),
        .cmd_ready_i(ready),
        .cmd_valid_o(valid),
        .cmd_op_o   (op),
        .busy_o     (busy),
        .repeating_o(rep)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) return i;
        end
        return 3;
    endfunction

    // Timeline model: follows a press through debounce, handshake, hold
    // (repeat thresholds) and release debounce, counting edges directly.
    initial begin : model
        int sel, n, cnt, thr;
        bit first, ok, released, done;
        @(posedge rst_n);
        forever begin
            @(posedge clk);
            if (btn != 4'b0000) begin
                sel = lowest(btn);
                exp_busy = 1'b1;
                ok = 1'b1;
                for (int k = 0; k < D; k++) begin
                    @(posedge clk);
                    if (!btn[sel]) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (!ok) begin
                    exp_busy = 1'b0;
                end else begin
                    first = 1'b1;
                    exp_op = sel[1:0];
                    exp_valid = 1'b1;
                    done = 1'b0;
                    while (!done) begin
                        do @(posedge clk); while (!ready);
                        exp_valid = 1'b0;
                        thr = first ? RD : RR;
                        n = 0;
                        released = 1'b0;
                        forever begin
                            @(posedge clk);
                            if (!btn[sel]) begin
                                released = 1'b1;
                                break;
                            end
                            n++;
                            if (sel != 3 && n == thr) break;
                        end
                        if (released) begin
                            cnt = 0;
                            while (cnt < D) begin
                                @(posedge clk);
                                if (btn[sel]) cnt = 0;
                                else cnt++;
                            end
                            exp_busy = 1'b0;
                            exp_rep = 1'b0;
                            done = 1'b1;
                        end else begin
                            first = 1'b0;
                            exp_rep = 1'b1;
                            exp_valid = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on && rst_n) begin
            check("valid", int'(valid), int'(exp_valid));
            if (exp_valid) check("op", int'(op), int'(exp_op));
            check("busy", int'(busy), int'(exp_busy));
            check("repeating", int'(rep), int'(exp_rep));
        end
    end

    // Event recorder: command start offsets relative to the press, and busy fall.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            rises.push_back(cyc - press_cyc);
            rise_ops.push_back(int'(op));
            rise_rep.push_back(int'(rep));
        end
        if (!busy && prev_busy) busy_fall = cyc;
        prev_valid = valid;
        prev_busy  = busy;
    end

    task automatic press(input logic [3:0] b);
        @(negedge clk);
        rises.delete();
        rise_ops.delete();
        rise_rep.delete();
        busy_fall = -1;
        press_cyc = cyc;
        btn = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: busy=%0d after %0d cycles, expected 0", name, busy, budget);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        #12;
        check("rst_valid", int'(valid), 0);
        check("rst_op", int'(op), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rep", int'(rep), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_on = 1'b1;

        // 1: single INC press, held 10 cycles
        press(4'b0001);
        hold(10);
        btn = 4'b0000;
        rel_cyc = cyc;
        wait_idle("t1", 40);
        check("t1_count", rises.size(), 1);
        if (rises.size() > 0) begin
            check("t1_latency", rises[0], 5);
            check("t1_op", rise_ops[0], 0);
        end
        // release sampled on the next edge, then D cycles of release debounce
        check("t1_busy_fall", busy_fall - rel_cyc, 5);

        // 2: bounces shorter than the debounce window
        press(4'b0010);
        @(negedge clk);
        check("t2_busy_on", int'(busy), 1);
        @(negedge clk);
        btn = 4'b0000;
        hold(3);
        check("t2_idle_a", int'(busy), 0);
        btn = 4'b0010;
        hold(2);
        btn = 4'b0000;
        hold(3);
        check("t2_idle_b", int'(busy), 0);
        check("t2_count", rises.size(), 0);

        // 3: SHL held 60 cycles -> delay then rate repeats
        press(4'b0100);
        hold(60);
        btn = 4'b0000;
        wait_idle("t3", 40);
        check("t3_count", rises.size(), 5);
        if (rises.size() == 5) begin
            check("t3_first", rises[0], 5);
            check("t3_second", rises[1], 26);
            check("t3_third", rises[2], 35);
            check("t3_fifth", rises[4], 53);
            check("t3_rep_first", rise_rep[0], 0);
            check("t3_rep_second", rise_rep[1], 1);
            check("t3_op", rise_ops[4], 2);
        end

        // 4: INC+DEC+CLR together; INC wins, DEC served after INC released
        press(4'b1011);
        hold(12);
        btn = 4'b1010;
        hold(20);
        btn = 4'b0000;
        wait_idle("t4", 40);
        check("t4_count", rises.size(), 2);
        if (rises.size() == 2) begin
            check("t4_op0", rise_ops[0], 0);
            check("t4_op1", rise_ops[1], 1);
            check("t4_dec_start", rises[1], 22);
        end

        // 5: CLR held 50 cycles -> one command, no repeat
        press(4'b1000);
        hold(50);
        btn = 4'b0000;
        wait_idle("t5", 40);
        check("t5_count", rises.size(), 1);
        if (rises.size() > 0) begin
            check("t5_op", rise_ops[0], 3);
            check("t5_rep", rise_rep[0], 0);
        end

        // 6: stalled handshake, then asynchronous reset mid-ISSUE
        ready = 1'b0;
        press(4'b0001);
        hold(8);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t6_stall_valid", int'(valid), 1);
            check("t6_stall_op", int'(op), 0);
        end
        #2;
        model_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", int'(valid), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_rep", int'(rep), 0);
        @(negedge clk);
        rst_n = 1'b1;
        btn = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
